// File: rtl/fifo_cfg_pkg.sv
// Shared configuration for the synchronous FIFO: default geometry, derived
// widths and the data word type used by the RTL and its bench.
package fifo_cfg_pkg;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = DEPTH - 2;
    localparam int AE_LEVEL = 2;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    typedef logic [WIDTH-1:0] fifo_data_t;

endpackage

// File: rtl/sync_fifo_core_if.sv
// Producer/consumer handshake, data and status bundle for sync_fifo_core.
// The master side is the environment, the slave side is the FIFO.
interface sync_fifo_core_if #(
    parameter int WIDTH = fifo_cfg_pkg::WIDTH,
    parameter int DEPTH = fifo_cfg_pkg::DEPTH
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage with one write port and one registered read port.
// Only the read register is reset; the array contents are don't-care.
module sync_fifo_mem #(
    parameter int WIDTH = fifo_cfg_pkg::WIDTH,
    parameter int DEPTH = fifo_cfg_pkg::DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it can map onto plain flops or RAM;
    // the pointers and count decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // A same-address read/write returns the old word, which is what a full
    // FIFO doing a simultaneous push and pop needs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO controller: pointers, occupancy count, status flags and
// one-cycle overflow/underflow pulses around a sync_fifo_mem array.
module sync_fifo_core #(
    parameter int WIDTH    = fifo_cfg_pkg::WIDTH,
    parameter int DEPTH    = fifo_cfg_pkg::DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = fifo_cfg_pkg::AE_LEVEL
) (
    input  logic            clk,
    input  logic            rst,
    sync_fifo_core_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             full_w;
    logic             empty_w;
    logic             rd_acc;
    logic             wr_acc;

    // Flags decode the registered count so they never lag it.
    assign full_w           = (count_q == CNT_W'(DEPTH));
    assign empty_w          = (count_q == '0);
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign bus.count        = count_q;

    // A full FIFO still takes a write when the same edge pops a word.
    assign rd_acc = bus.rd_en & ~empty_w;
    assign wr_acc = bus.wr_en & (~full_w | rd_acc);

    // NOTE: all state here updates with non-blocking assignments so every
    // term above is evaluated on the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            bus.rd_valid  <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            bus.rd_valid  <= rd_acc;
            bus.overflow  <= bus.wr_en & ~wr_acc;
            bus.underflow <= bus.rd_en & ~rd_acc;
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (bus.rd_data)
    );

endmodule
